// File: rtl/rr_arb_sched.sv
// Round-robin grant scheduler: rotating-priority arbitration, fixed decision-to-grant
// latency, grant held until owner's done. Optional hold timeout via RR_ARB_SCHED_TIMEOUT_EN.
module rr_arb_sched #(
  parameter int NUM_REQ  = 3,
  parameter int REQ2GNT  = 2,
  parameter int MAX_HOLD = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ-1:0]         done,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [$clog2(NUM_REQ)-1:0] gnt_id,
  output logic                       busy,
  output logic                       timeout_err
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int LAT_W = $clog2(REQ2GNT + 1);

  if (NUM_REQ < 2 || NUM_REQ > 8 || REQ2GNT < 1 || MAX_HOLD < 2) begin : g_param_check
    $error("rr_arb_sched: parameter out of range");
  end

  typedef enum logic [1:0] {IDLE, WAIT, GRANT} state_t;

  state_t              state_q;
  logic [ID_W-1:0]     ptr_q;
  logic [ID_W-1:0]     gnt_id_q;
  logic [NUM_REQ-1:0]  gnt_q;
  logic                busy_q;
  logic                timeout_q;
  logic [LAT_W-1:0]    lat_q;

  logic [ID_W:0]       cand_sum [NUM_REQ];
  logic [ID_W-1:0]     cand_idx [NUM_REQ];
  logic [NUM_REQ-1:0]  cand_hit;
  logic [NUM_REQ-1:0]  win_oh;
  logic [NUM_REQ-1:0]  owner_oh;
  logic [ID_W-1:0]     win_idx;
  logic                owner_done;
  logic                hold_expired;

  // Candidate gi is the requester at offset gi+1 past the last winner, wrapped modulo NUM_REQ.
  genvar gi;
  for (gi = 0; gi < NUM_REQ; gi++) begin : g_cand
    assign cand_sum[gi] = {1'b0, ptr_q} + (ID_W+1)'(gi + 1);
    assign cand_idx[gi] = (cand_sum[gi] >= (ID_W+1)'(NUM_REQ))
                          ? ID_W'(cand_sum[gi] - (ID_W+1)'(NUM_REQ))
                          : cand_sum[gi][ID_W-1:0];
    assign cand_hit[gi] = req[cand_idx[gi]];
    assign win_oh[gi]   = (win_idx == ID_W'(gi));
    assign owner_oh[gi] = (gnt_id_q == ID_W'(gi));
  end

  // Walk offsets from the far end so the nearest asserted candidate wins.
  always_comb begin
    win_idx = cand_idx[0];
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (cand_hit[i]) begin
        win_idx = cand_idx[i];
      end
    end
  end

  assign owner_done = |(done & owner_oh);

`ifdef RR_ARB_SCHED_TIMEOUT_EN
  localparam int HOLD_W = $clog2(MAX_HOLD + 1);

  logic [HOLD_W-1:0] hold_q;

  // Holds 1 on the first grant cycle and counts grant cycles from there.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_q <= HOLD_W'(1);
    end else if (state_q == GRANT) begin
      hold_q <= hold_q + HOLD_W'(1);
    end else begin
      hold_q <= HOLD_W'(1);
    end
  end

  assign hold_expired = (state_q == GRANT) && (hold_q == HOLD_W'(MAX_HOLD));
`else
  assign hold_expired = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      ptr_q     <= ID_W'(NUM_REQ - 1);
      gnt_id_q  <= '0;
      gnt_q     <= '0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
      lat_q     <= '0;
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (|req) begin
            gnt_id_q <= win_idx;
            busy_q   <= 1'b1;
            if (REQ2GNT == 1) begin
              state_q <= GRANT;
              gnt_q   <= win_oh;
            end else begin
              state_q <= WAIT;
              lat_q   <= LAT_W'(REQ2GNT - 1);
            end
          end
        end
        WAIT: begin
          // The winner is committed here; req and done are not looked at.
          if (lat_q == LAT_W'(1)) begin
            state_q <= GRANT;
            gnt_q   <= owner_oh;
          end else begin
            lat_q <= lat_q - LAT_W'(1);
          end
        end
        GRANT: begin
          if (owner_done || hold_expired) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            busy_q    <= 1'b0;
            ptr_q     <= gnt_id_q;
            timeout_q <= !owner_done;
          end
        end
        default: begin
          state_q <= IDLE;
          gnt_q   <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign gnt         = gnt_q;
  assign gnt_id      = gnt_id_q;
  assign busy        = busy_q;
  assign timeout_err = timeout_q;

endmodule

// File: tb/tb_rr_arb_sched.sv
// Directed bench for rr_arb_sched (NUM_REQ=3, REQ2GNT=2, MAX_HOLD=16); cycle 0 is the
// first cycle after reset is sampled. Timeout scenario depends on RR_ARB_SCHED_TIMEOUT_EN.
module tb_rr_arb_sched;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] req;
  logic [2:0] done;
  logic [2:0] gnt;
  logic [1:0] gnt_id;
  logic       busy;
  logic       timeout_err;

  int n_checks = 0;
  int n_errors = 0;

  rr_arb_sched #(.NUM_REQ(3), .REQ2GNT(2), .MAX_HOLD(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .done        (done),
    .gnt         (gnt),
    .gnt_id      (gnt_id),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = 3'b000;
    done  = 3'b000;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (gnt !== 3'b000) begin n_errors++; $display("FAIL reset_gnt got=%b exp=000", gnt); end
    n_checks++;
    if (gnt_id !== 2'd0) begin n_errors++; $display("FAIL reset_gnt_id got=%0d exp=0", gnt_id); end
    n_checks++;
    if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_checks++;
    if (timeout_err !== 1'b0) begin n_errors++; $display("FAIL reset_timeout got=%b exp=0", timeout_err); end
    $display("test_reset: outputs checked at cycle 0");
  endtask

  task automatic test_fairness();
    logic [2:0] exp_gnt;
    logic [1:0] exp_id;
    do_reset();
    for (int c = 0; c <= 16; c++) begin
      exp_gnt = 3'b000;
      exp_id  = 2'd0;
      if (c == 2 || c == 3)   begin exp_gnt = 3'b001; exp_id = 2'd0; end
      if (c == 6 || c == 7)   begin exp_gnt = 3'b010; exp_id = 2'd1; end
      if (c == 10 || c == 11) begin exp_gnt = 3'b100; exp_id = 2'd2; end
      if (c == 14 || c == 15) begin exp_gnt = 3'b001; exp_id = 2'd0; end
      n_checks++;
      if (gnt !== exp_gnt) begin
        n_errors++; $display("FAIL fairness_gnt cyc=%0d got=%b exp=%b", c, gnt, exp_gnt);
      end
      if (exp_gnt != 3'b000) begin
        n_checks++;
        if (gnt_id !== exp_id) begin
          n_errors++; $display("FAIL fairness_gnt_id cyc=%0d got=%0d exp=%0d", c, gnt_id, exp_id);
        end
      end
      req  = (c < 16) ? 3'b111 : 3'b000;
      done = 3'b000;
      if (c == 3 || c == 15) done = 3'b001;
      if (c == 7)            done = 3'b010;
      if (c == 11)           done = 3'b100;
      tick();
    end
    done = 3'b000;
    $display("test_fairness: grants 0,1,2,0 checked over cycles 0-16");
  endtask

  task automatic test_single_requester();
    logic [2:0] exp_gnt;
    logic       exp_busy;
    do_reset();
    for (int c = 0; c <= 6; c++) begin
      exp_gnt  = (c >= 2 && c <= 5) ? 3'b100 : 3'b000;
      exp_busy = (c >= 1 && c <= 5);
      n_checks++;
      if (gnt !== exp_gnt) begin
        n_errors++; $display("FAIL single_gnt cyc=%0d got=%b exp=%b", c, gnt, exp_gnt);
      end
      n_checks++;
      if (busy !== exp_busy) begin
        n_errors++; $display("FAIL single_busy cyc=%0d got=%b exp=%b", c, busy, exp_busy);
      end
      if (c == 4) begin
        n_checks++;
        if (gnt_id !== 2'd2) begin
          n_errors++; $display("FAIL single_gnt_id cyc=%0d got=%0d exp=2", c, gnt_id);
        end
      end
      req  = (c < 6) ? 3'b100 : 3'b000;
      done = 3'b000;
      if (c == 3) done = 3'b001;
      if (c == 5) done = 3'b100;
      tick();
    end
    done = 3'b000;
    $display("test_single_requester: non-owner done ignored, release at cycle 6");
  endtask

  task automatic test_committed();
    logic [2:0] exp_gnt;
    do_reset();
    for (int c = 0; c <= 8; c++) begin
      exp_gnt = (c >= 2 && c <= 7) ? 3'b001 : 3'b000;
      n_checks++;
      if (gnt !== exp_gnt) begin
        n_errors++; $display("FAIL committed_gnt cyc=%0d got=%b exp=%b", c, gnt, exp_gnt);
      end
      req  = (c == 0) ? 3'b001 : 3'b000;
      done = (c == 7) ? 3'b001 : 3'b000;
      tick();
    end
    done = 3'b000;
    $display("test_committed: grant survived req drop until done");
  endtask

`ifdef RR_ARB_SCHED_TIMEOUT_EN
  task automatic test_timeout();
    logic [2:0] exp_gnt;
    logic       exp_to;
    do_reset();
    for (int c = 0; c <= 20; c++) begin
      exp_gnt = 3'b000;
      if (c >= 2 && c <= 17) exp_gnt = 3'b010;
      if (c == 20)           exp_gnt = 3'b100;
      exp_to = (c == 18);
      n_checks++;
      if (gnt !== exp_gnt) begin
        n_errors++; $display("FAIL timeout_gnt cyc=%0d got=%b exp=%b", c, gnt, exp_gnt);
      end
      n_checks++;
      if (timeout_err !== exp_to) begin
        n_errors++; $display("FAIL timeout_err cyc=%0d got=%b exp=%b", c, timeout_err, exp_to);
      end
      if (c == 20) begin
        n_checks++;
        if (gnt_id !== 2'd2) begin
          n_errors++; $display("FAIL timeout_next_id cyc=%0d got=%0d exp=2", c, gnt_id);
        end
      end
      req  = (c < 18) ? 3'b010 : 3'b111;
      done = 3'b000;
      tick();
    end
    $display("test_timeout: forced release at cycle 18, next grant to req[2]");
  endtask
`else
  task automatic test_no_timeout();
    logic [2:0] exp_gnt;
    do_reset();
    for (int c = 0; c <= 41; c++) begin
      exp_gnt = (c >= 2) ? 3'b001 : 3'b000;
      n_checks++;
      if (gnt !== exp_gnt) begin
        n_errors++; $display("FAIL hold_gnt cyc=%0d got=%b exp=%b", c, gnt, exp_gnt);
      end
      n_checks++;
      if (timeout_err !== 1'b0) begin
        n_errors++; $display("FAIL hold_timeout_err cyc=%0d got=%b exp=0", c, timeout_err);
      end
      req  = 3'b001;
      done = 3'b000;
      tick();
    end
    $display("test_no_timeout: grant held 40 cycles without done");
  endtask
`endif

  task automatic test_reset_mid_grant();
    logic [2:0] exp_gnt;
    do_reset();
    for (int c = 0; c <= 3; c++) begin
      req = 3'b010;
      tick();
    end
    n_checks++;
    if (gnt !== 3'b010) begin
      n_errors++; $display("FAIL midrst_pre_gnt got=%b exp=010", gnt);
    end
    reset = 1'b1;
    req   = 3'b111;
    tick();
    reset = 1'b0;
    n_checks++;
    if (gnt !== 3'b000) begin n_errors++; $display("FAIL midrst_gnt got=%b exp=000", gnt); end
    n_checks++;
    if (busy !== 1'b0) begin n_errors++; $display("FAIL midrst_busy got=%b exp=0", busy); end
    for (int c = 0; c <= 2; c++) begin
      exp_gnt = (c == 2) ? 3'b001 : 3'b000;
      if (c > 0) begin
        n_checks++;
        if (gnt !== exp_gnt) begin
          n_errors++; $display("FAIL midrst_post_gnt cyc=%0d got=%b exp=%b", c, gnt, exp_gnt);
        end
      end
      req = 3'b111;
      tick();
    end
    n_checks++;
    if (gnt_id !== 2'd0) begin
      n_errors++; $display("FAIL midrst_post_id got=%0d exp=0", gnt_id);
    end
    $display("test_reset_mid_grant: grant dropped, req[0] first after reset");
  endtask

  initial begin
    reset = 1'b1;
    req   = 3'b000;
    done  = 3'b000;
    test_reset();
    test_fairness();
    test_single_requester();
    test_committed();
`ifdef RR_ARB_SCHED_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    test_reset_mid_grant();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
